// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the byte-serial memory bus. Serves RAM reads with
//   one cycle of latency and accepts RAM byte writes. It also decodes an I/O window
//   (mem_a_in[17:16] == 2'b11) that holds a tx FIFO, an rx FIFO, a status register
//   and a sticky halt request.
//
// Ports
//   clk_in           sole clock, rising edge
//   rst_n_in         asynchronous active-low reset
//   rdy_in           global ready; low freezes bus-side state
//   mem_a_in         byte address
//   mem_d_in         write data
//   mem_wr_in        1 = write, 0 = read
//   mem_d_out        registered read data
//   io_tx_valid_out  tx FIFO non-empty
//   io_tx_data_out   tx FIFO head byte
//   io_tx_ready_in   consumer accepts tx head this cycle
//   io_rx_valid_in   incoming rx byte present
//   io_rx_data_in    incoming rx byte
//   io_full_out      tx back-pressure (occupancy >= FIFO_DEPTH-2)
//   halt_out         sticky halt request
module mem_responder #(
    parameter int RAM_ADDR_BITS = 17,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a_in,
    input  logic [7:0]  mem_d_in,
    input  logic        mem_wr_in,
    output logic [7:0]  mem_d_out,
    output logic        io_tx_valid_out,
    output logic [7:0]  io_tx_data_out,
    input  logic        io_tx_ready_in,
    input  logic        io_rx_valid_in,
    input  logic [7:0]  io_rx_data_in,
    output logic        io_full_out,
    output logic        halt_out
);

    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_MARK = (PW+1)'(FIFO_DEPTH - 2);
    localparam logic [PW:0] PTR_ONE   = (PW+1)'(1);

    logic [7:0] ram [0:(1 << RAM_ADDR_BITS) - 1];

    logic [7:0] tx_mem [0:FIFO_DEPTH-1];
    logic [7:0] rx_mem [0:FIFO_DEPTH-1];
    logic [PW:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [PW:0] tx_occ;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic is_io, sel_status;
    logic tx_push, tx_drop, tx_pop;
    logic rx_push, rx_drop, rx_pop;
    logic data_rd, data_wr, status_rd, status_wr;
    logic tx_ovf, rx_ovf;
    logic [7:0] status_val;

    // Address bits above the I/O decode are not part of this responder's map.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_a_in[31:18];

    assign is_io      = (mem_a_in[17:16] == 2'b11);
    assign sel_status = mem_a_in[2];

    assign data_rd   = rdy_in && is_io && !sel_status && !mem_wr_in;
    assign data_wr   = rdy_in && is_io && !sel_status &&  mem_wr_in;
    assign status_rd = rdy_in && is_io &&  sel_status && !mem_wr_in;
    assign status_wr = rdy_in && is_io &&  sel_status &&  mem_wr_in;

    assign tx_empty = (tx_wr == tx_rd);
    assign tx_full  = (tx_wr[PW-1:0] == tx_rd[PW-1:0]) && (tx_wr[PW] != tx_rd[PW]);
    assign rx_empty = (rx_wr == rx_rd);
    assign rx_full  = (rx_wr[PW-1:0] == rx_rd[PW-1:0]) && (rx_wr[PW] != rx_rd[PW]);
    assign tx_occ   = tx_wr - tx_rd;

    // Full is judged on the pre-edge pointers, so a push into a full FIFO is
    // rejected even if a pop happens on the same edge.
    assign tx_push = data_wr && !tx_full;
    assign tx_drop = data_wr &&  tx_full;
    assign tx_pop  = !tx_empty && io_tx_ready_in;
    assign rx_push = io_rx_valid_in && !rx_full;
    assign rx_drop = io_rx_valid_in &&  rx_full;
    assign rx_pop  = data_rd && !rx_empty;

    assign io_tx_valid_out = !tx_empty;
    assign io_tx_data_out  = tx_empty ? 8'h00 : tx_mem[tx_rd[PW-1:0]];
    assign io_full_out     = (tx_occ >= FULL_MARK);

    assign status_val = {4'b0000, rx_ovf, tx_ovf, !rx_empty, tx_full};

    // RAM contents and FIFO storage are not reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !is_io && mem_wr_in) begin
            ram[mem_a_in[RAM_ADDR_BITS-1:0]] <= mem_d_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wr[PW-1:0]] <= mem_d_in;
        end
        if (rx_push) begin
            rx_mem[rx_wr[PW-1:0]] <= io_rx_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tx_wr <= '0;
            tx_rd <= '0;
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + PTR_ONE;
            if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
            if (rx_push) rx_wr <= rx_wr + PTR_ONE;
            if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
        end
    end

    // Overflow flags: a drop on the same edge as a status read keeps the flag set.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tx_ovf   <= 1'b0;
            rx_ovf   <= 1'b0;
            halt_out <= 1'b0;
        end else begin
            if (tx_drop)        tx_ovf <= 1'b1;
            else if (status_rd) tx_ovf <= 1'b0;
            if (rx_drop)        rx_ovf <= 1'b1;
            else if (status_rd) rx_ovf <= 1'b0;
            if (status_wr && mem_d_in[0]) halt_out <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_d_out <= 8'h00;
        end else if (rdy_in) begin
            if (!is_io) begin
                mem_d_out <= mem_wr_in ? 8'h00 : ram[mem_a_in[RAM_ADDR_BITS-1:0]];
            end else if (mem_wr_in) begin
                mem_d_out <= 8'h00;
            end else if (sel_status) begin
                mem_d_out <= status_val;
            end else begin
                mem_d_out <= rx_empty ? 8'h00 : rx_mem[rx_rd[PW-1:0]];
            end
        end
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the byte-serial memory bus driven by the memory allocator. Serves one byte per cycle from on-chip RAM with fixed one-cycle read latency, accepts byte writes, and decodes a memory-mapped I/O window with a transmit FIFO, a receive FIFO, a status register and a halt control. Sits at the top level between the allocator's mem_* port and the external byte-stream I/O.

## Interface
- RAM_ADDR_BITS, 17: RAM is 2^RAM_ADDR_BITS bytes, indexed by mem_a_in[RAM_ADDR_BITS-1:0].
- FIFO_DEPTH, 8: depth of each I/O FIFO; power of two, ≥4.
- clk_in  input  1  sole clock; all state changes on rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; low freezes bus-side state (RAM, rx pop, tx push, status, halt).
- mem_a_in  input  32  byte address from allocator.
- mem_d_in  input  8  write data.
- mem_wr_in  input  1  1 = write, 0 = read.
- mem_d_out  output  8  read data, registered.
- io_tx_valid_out  output  1  tx FIFO non-empty.
- io_tx_data_out  output  8  tx FIFO head byte.
- io_tx_ready_in  input  1  consumer accepts head this cycle.
- io_rx_valid_in  input  1  incoming byte present.
- io_rx_data_in  input  8  incoming byte.
- io_full_out  output  1  tx back-pressure to top level (drives rdy low).
- halt_out  output  1  sticky halt request.

## Operation
- Decode: I/O when mem_a_in[17:16]==2'b11, else RAM. I/O register select = mem_a_in[2]: 0 = DATA, 1 = STATUS. Other I/O address bits ignored.
- RAM read: mem_d_out <= ram[a]. RAM write: ram[a] <= mem_d_in; mem_d_out <= 0.
- DATA write: push mem_d_in into tx FIFO if not full; if full, drop byte, set tx_ovf.
- DATA read: mem_d_out <= rx head and pop if rx non-empty; else mem_d_out <= 0, no pop.
- STATUS read: mem_d_out <= {4'b0, rx_ovf, tx_ovf, rx_nonempty, tx_full}; clears tx_ovf and rx_ovf. A set in the same cycle wins over the clear.
- STATUS write: if mem_d_in[0], halt_out <= 1 (sticky until reset); other bits ignored.
- rx FIFO: when io_rx_valid_in and not full, push io_rx_data_in; if full, drop and set rx_ovf. Runs regardless of rdy_in.
- tx FIFO: pop when io_tx_valid_out && io_tx_ready_in. Runs regardless of rdy_in. io_tx_data_out = head; it is meaningless when empty.
- FIFOs: read/write pointers of log2(FIFO_DEPTH)+1 bits. Empty when pointers are equal. Full when the low bits are equal and the MSBs differ. Pointers wrap modulo 2·FIFO_DEPTH.
- Simultaneous push and pop on either FIFO: both take effect, occupancy unchanged. Push while full with pop in the same cycle is still rejected, because full is evaluated before pop.
- io_full_out = tx occupancy ≥ FIFO_DEPTH−2, combinational from pointers. The two-slot margin absorbs the allocator's in-flight write bytes.
- rdy_in low: mem_d_out holds, no RAM write, no tx push, no rx pop, no status clear, no halt change.

## Timing
- Reset (asynchronous, immediate): mem_d_out=0, both FIFOs empty, io_tx_valid_out=0, io_tx_data_out=0, io_full_out=0, tx_ovf=rx_ovf=0, halt_out=0. RAM contents are not reset.
- Read latency 1: address sampled at edge k, data on mem_d_out after edge k; the allocator samples it at edge k+1. Back-to-back reads yield one byte per cycle.
- Write visible to a read of the same address issued on the next cycle. A read and a write cannot coincide because the bus carries one transaction per cycle.
- Tx push at edge k: io_tx_valid_out high after edge k. Rx push at edge k: readable by a DATA read sampled at edge k+1 or later.
- Reset deasserted mid-stream: the first edge after release is treated as a normal cycle. Nothing in flight is retained.

## Test plan
- Write 0xA5 to RAM 0x00010, then read 0x00010 -> mem_d_out=0xA5 one edge after the read address; four consecutive reads of 0x0..0x3 return a byte per cycle in order.
- Hold io_tx_ready_in=0 and write DATA (0x30000) nine times with 0x01..0x09 -> io_full_out rises after the 6th push; the 9th byte is dropped. STATUS read -> 0x05. A second STATUS read -> 0x01.
- Release io_tx_ready_in=1 -> io_tx_data_out sequence 0x01..0x08, one per cycle, then io_tx_valid_out=0. With ready held high, a DATA write and a pop in the same cycle leave occupancy unchanged.
- Push rx 0x41, 0x42 -> DATA reads return 0x41, 0x42, then 0x00. STATUS bit1 is 1 before the reads and 0 after.
- Pulse rdy_in=0 during a DATA read and a STATUS write of 0x01 -> no rx pop, halt_out stays 0. With rdy_in=1, repeat the STATUS write -> halt_out=1 and stays 1.
- Assert rst_n_in low between edges with both FIFOs partly full -> all outputs zero immediately, before the next clock edge.
